// File: rtl/dm_if.sv
// dm_if: request/response bus between the MIPS32 datapath and dm_ctrl.
// The master drives requests; the slave accepts them and returns a registered response.
interface dm_if #(
  parameter int ADDR_W = 14
);
  logic              req_valid;
  logic              req_ready;
  logic              req_we;
  logic [1:0]        req_size;
  logic              req_signed;
  logic [ADDR_W-1:0] req_addr;
  logic [31:0]       req_wdata;
  logic              rsp_valid;
  logic [31:0]       rsp_rdata;
  logic              rsp_err;

  modport master (
    output req_valid, req_we, req_size, req_signed, req_addr, req_wdata,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err
  );

  modport slave (
    input  req_valid, req_we, req_size, req_signed, req_addr, req_wdata,
    output req_ready, rsp_valid, rsp_rdata, rsp_err
  );
endinterface

// File: rtl/dm_ctrl.sv
// dm_ctrl: word-organised little-endian data memory with byte enables,
// valid/ready request port, 1-cycle registered response, error flagging and
// a hardware clear sequencer after reset.
// Optional: define DM_ERR_COUNT_EN to add a saturating err_count output.
module dm_ctrl #(
  parameter int ADDR_W         = 14,
  parameter int DEPTH_BYTES    = 12288,
  parameter int CLEAR_ON_RESET = 1
) (
  input  logic        clk,
  input  logic        reset,
  dm_if.slave         bus,
`ifdef DM_ERR_COUNT_EN
  output logic [15:0] err_count,
`endif
  output logic        busy
);
  localparam int WORDS = DEPTH_BYTES / 4;
  localparam int WI    = (WORDS > 1) ? $clog2(WORDS) : 1;

  typedef enum logic {S_CLEAR, S_READY} state_e;

  state_e          state_q;
  logic [WI-1:0]   cnt_q;
  logic [3:0][7:0] mem_q [WORDS];

  logic            rsp_valid_q, rsp_err_q;
  logic [31:0]     rsp_rdata_q;

  logic            ready, acc, err, st_we, clr_we;
  logic [2:0]      nbytes;
  logic [1:0]      lane;
  logic [WI-1:0]   idx;
  logic [3:0]      be;
  logic [3:0][7:0] wd;
  logic [3:0][7:0] rd_word;
  logic [7:0]      rd_b;
  logic [15:0]     rd_h;
  logic [31:0]     ld_d;
  logic [31:0]     addr32;

  // Requests are refused while reset is held so nothing is accepted mid-restart.
  assign ready         = (state_q == S_READY) && !reset;
  assign bus.req_ready = ready;
  assign busy          = (state_q == S_CLEAR);
  assign acc           = bus.req_valid && ready;
  assign clr_we        = (state_q == S_CLEAR);

  assign lane   = bus.req_addr[1:0];
  assign idx    = bus.req_addr[WI+1:2];
  assign addr32 = 32'(bus.req_addr);

  // Access size in bytes, used for the upper range bound.
  always_comb begin
    nbytes = 3'd4;
    case (bus.req_size)
      2'b00:   nbytes = 3'd1;
      2'b01:   nbytes = 3'd2;
      default: nbytes = 3'd4;
    endcase
  end

  // Alignment, illegal size and range check; the last byte touched must lie in the array.
  assign err = (bus.req_size == 2'b11) ||
               (bus.req_size == 2'b01 && bus.req_addr[0]) ||
               (bus.req_size == 2'b10 && lane != 2'b00) ||
               (addr32 > (32'(DEPTH_BYTES) - 32'(nbytes)));

  assign st_we = acc && bus.req_we && !err;

  // Byte enables and lane-replicated store data.
  always_comb begin
    be = 4'b0000;
    wd = bus.req_wdata;
    case (bus.req_size)
      2'b00: begin
        be = 4'b0001 << lane;
        wd = {4{bus.req_wdata[7:0]}};
      end
      2'b01: begin
        be = bus.req_addr[1] ? 4'b1100 : 4'b0011;
        wd = {2{bus.req_wdata[15:0]}};
      end
      2'b10: be = 4'b1111;
      default: be = 4'b0000;
    endcase
  end

  // Array write port, shared by the clear sequencer and byte-enabled stores.
  always_ff @(posedge clk) begin
    if (clr_we) mem_q[cnt_q] <= '0;
    else if (st_we) begin
      for (int l = 0; l < 4; l++)
        if (be[l]) mem_q[idx][l] <= wd[l];
    end
  end

  // Lane select and sign/zero extension of the addressed word.
  always_comb begin
    rd_word = mem_q[idx];
    rd_b    = rd_word[lane];
    rd_h    = bus.req_addr[1] ? {rd_word[3], rd_word[2]} : {rd_word[1], rd_word[0]};
    ld_d    = rd_word;
    case (bus.req_size)
      2'b00:   ld_d = bus.req_signed ? {{24{rd_b[7]}}, rd_b} : {24'b0, rd_b};
      2'b01:   ld_d = bus.req_signed ? {{16{rd_h[15]}}, rd_h} : {16'b0, rd_h};
      default: ld_d = rd_word;
    endcase
  end

  // Clear sequencer: one word per cycle, then READY for good.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= (CLEAR_ON_RESET != 0) ? S_CLEAR : S_READY;
      cnt_q   <= '0;
    end else begin
      case (state_q)
        S_CLEAR: begin
          cnt_q <= cnt_q + 1'b1;
          if (cnt_q == WI'(WORDS - 1)) state_q <= S_READY;
        end
        default: state_q <= S_READY;
      endcase
    end
  end

  // Registered response; data and error hold when no request was accepted.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rsp_valid_q <= 1'b0;
      rsp_err_q   <= 1'b0;
      rsp_rdata_q <= '0;
    end else begin
      rsp_valid_q <= acc;
      if (acc) begin
        rsp_err_q   <= err;
        rsp_rdata_q <= (err || bus.req_we) ? 32'h0 : ld_d;
      end
    end
  end

  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_err   = rsp_err_q;
  assign bus.rsp_rdata = rsp_rdata_q;

`ifdef DM_ERR_COUNT_EN
  logic [15:0] err_cnt_q;

  // Saturating count of accepted requests that were flagged.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) err_cnt_q <= '0;
    else if (acc && err && err_cnt_q != 16'hFFFF) err_cnt_q <= err_cnt_q + 16'd1;
  end

  assign err_count = err_cnt_q;
`endif
endmodule

// File: tb/tb_dm_ctrl.sv
// tb_dm_ctrl: directed checks of dm_ctrl with a 64-byte array and clear-on-reset.
module tb_dm_ctrl;
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic busy;
  int   total = 0;
  int   bad   = 0;
`ifdef DM_ERR_COUNT_EN
  logic [15:0] err_count;
`endif

  dm_if #(.ADDR_W(8)) bus ();

  dm_ctrl #(.ADDR_W(8), .DEPTH_BYTES(64), .CLEAR_ON_RESET(1)) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus),
`ifdef DM_ERR_COUNT_EN
    .err_count(err_count),
`endif
    .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic cmp(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Check the response currently on the bus.
  task automatic chk(input string tag, input logic ev, input logic ee, input logic [31:0] ed);
    cmp({tag, ".valid"}, 32'(bus.rsp_valid), 32'(ev));
    cmp({tag, ".err"},   32'(bus.rsp_err),   32'(ee));
    cmp({tag, ".rdata"}, bus.rsp_rdata, ed);
  endtask

  // Present one request at the falling edge; idle cycles carry junk that must be ignored.
  task automatic cyc(input logic v, input logic we, input logic [1:0] sz, input logic sg,
                     input logic [7:0] a, input logic [31:0] wdat);
    @(negedge clk);
    bus.req_valid  = v;
    bus.req_we     = v ? we : 1'b1;
    bus.req_size   = v ? sz : 2'b10;
    bus.req_signed = sg;
    bus.req_addr   = v ? a : 8'h20;
    bus.req_wdata  = v ? wdat : 32'hFFFF_FFFF;
  endtask

  task automatic idle();
    cyc(1'b0, 1'b0, 2'b00, 1'b0, 8'h00, 32'h0);
  endtask

  // Counts rising edges until busy drops, bounded.
  task automatic wait_clear(input string tag);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (busy && n < 100);
    cmp({tag, ".cycles"}, 32'(n), 32'd16);
    cmp({tag, ".ready"}, 32'(bus.req_ready), 32'd1);
  endtask

  initial begin
    bus.req_valid  = 1'b0;
    bus.req_we     = 1'b0;
    bus.req_size   = 2'b00;
    bus.req_signed = 1'b0;
    bus.req_addr   = '0;
    bus.req_wdata  = '0;

    // reset state
    repeat (3) @(negedge clk);
    cmp("rst.ready", 32'(bus.req_ready), 32'd0);
    cmp("rst.busy",  32'(busy), 32'd1);
    chk("rst", 1'b0, 1'b0, 32'h0);
`ifdef DM_ERR_COUNT_EN
    cmp("rst.errcnt", 32'(err_count), 32'd0);
`endif
    reset = 1'b0;
    wait_clear("clr1");

    // every word cleared, back-to-back loads
    for (int i = 0; i <= 16; i++) begin
      cyc(i < 16, 1'b0, 2'b10, 1'b0, 8'(i * 4), 32'h0);
      if (i > 0) chk($sformatf("clrlw%0d", i - 1), 1'b1, 1'b0, 32'h0);
    end
    idle(); chk("idle0", 1'b0, 1'b0, 32'h0);

    // sub-word loads with extension
    cyc(1, 1, 2'b10, 0, 8'h10, 32'h8081F2F3);
    cyc(1, 0, 2'b00, 1, 8'h10, 32'h0);  chk("sw10", 1, 0, 32'h0);
    cyc(1, 0, 2'b00, 0, 8'h11, 32'h0);  chk("lb10", 1, 0, 32'hFFFFFFF3);
    cyc(1, 0, 2'b01, 1, 8'h12, 32'h0);  chk("lbu11", 1, 0, 32'h000000F2);
    cyc(1, 0, 2'b01, 0, 8'h12, 32'h0);  chk("lh12", 1, 0, 32'hFFFF8081);
    idle();                             chk("lhu12", 1, 0, 32'h00008081);
    idle();                             chk("hold", 0, 0, 32'h00008081);

    // byte enables
    cyc(1, 1, 2'b10, 0, 8'h20, 32'h11223344);
    cyc(1, 1, 2'b00, 0, 8'h21, 32'hFFFFFFAA); chk("sw20", 1, 0, 32'h0);
    cyc(1, 0, 2'b10, 0, 8'h20, 32'h0);        chk("sb21", 1, 0, 32'h0);
    cyc(1, 1, 2'b01, 0, 8'h22, 32'h1234BEEF); chk("lw20a", 1, 0, 32'h1122AA44);
    cyc(1, 0, 2'b10, 0, 8'h20, 32'h0);        chk("sh22", 1, 0, 32'h0);
    idle();                                   chk("lw20b", 1, 0, 32'hBEEFAA44);

    // errors and range boundaries
    cyc(1, 1, 2'b10, 0, 8'h00, 32'hCAFEF00D);
    cyc(1, 1, 2'b10, 0, 8'h3C, 32'h5A5A5A5A); chk("sw00", 1, 0, 32'h0);
    cyc(1, 0, 2'b10, 0, 8'h02, 32'h0);        chk("sw3c", 1, 0, 32'h0);
    cyc(1, 1, 2'b01, 0, 8'h03, 32'h0000FFFF); chk("e.lw02", 1, 1, 32'h0);
    cyc(1, 1, 2'b11, 0, 8'h00, 32'hFFFFFFFF); chk("e.sh03", 1, 1, 32'h0);
    cyc(1, 0, 2'b10, 0, 8'd62, 32'h0);        chk("e.sz11", 1, 1, 32'h0);
    cyc(1, 0, 2'b10, 0, 8'd64, 32'h0);        chk("e.lw62", 1, 1, 32'h0);
    cyc(1, 0, 2'b00, 0, 8'd64, 32'h0);        chk("e.lw64", 1, 1, 32'h0);
    cyc(1, 0, 2'b10, 0, 8'h00, 32'h0);        chk("e.lb64", 1, 1, 32'h0);
    cyc(1, 0, 2'b10, 0, 8'd60, 32'h0);        chk("lw00", 1, 0, 32'hCAFEF00D);
    cyc(1, 0, 2'b00, 1, 8'd63, 32'h0);        chk("lw60", 1, 0, 32'h5A5A5A5A);
    cyc(1, 0, 2'b01, 1, 8'd62, 32'h0);        chk("lb63", 1, 0, 32'h0000005A);
    idle();                                   chk("lh62", 1, 0, 32'h00005A5A);
`ifdef DM_ERR_COUNT_EN
    cmp("errcnt", 32'(err_count), 32'd6);
`endif

    // store then load the same word
    cyc(1, 1, 2'b10, 0, 8'h30, 32'h12345678);
    cyc(1, 0, 2'b10, 0, 8'h30, 32'h0);        chk("sw30", 1, 0, 32'h0);
    @(negedge clk);                           chk("lw30", 1, 0, 32'h12345678);

    // reset together with a presented store: outputs clear at once
    reset = 1'b1;
    bus.req_valid = 1'b1; bus.req_we = 1'b1; bus.req_size = 2'b10;
    bus.req_addr = 8'h30; bus.req_wdata = 32'hDEADBEEF;
    #1;
    chk("rst2", 1'b0, 1'b0, 32'h0);
    cmp("rst2.ready", 32'(bus.req_ready), 32'd0);
    cmp("rst2.busy",  32'(busy), 32'd1);
    repeat (2) @(negedge clk);
    reset = 1'b0;

    // reset again in cycle 5 of the clear
    repeat (5) @(negedge clk);
    cmp("mid.busy", 32'(busy), 32'd1);
    reset = 1'b1;
    #1;
    cmp("mid.ready", 32'(bus.req_ready), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    wait_clear("clr2");
    bus.req_valid = 1'b0;
`ifdef DM_ERR_COUNT_EN
    cmp("errcnt.rst", 32'(err_count), 32'd0);
`endif

    cyc(1, 0, 2'b10, 0, 8'h30, 32'h0);
    cyc(1, 0, 2'b10, 0, 8'h00, 32'h0);        chk("post.lw30", 1, 0, 32'h0);
    idle();                                   chk("post.lw00", 1, 0, 32'h0);
    idle();                                   chk("post.idle", 0, 0, 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Hard stop in case the sequence ever stalls.
  initial begin
    #200000;
    $display("FAIL timeout total=%0d bad=%0d", total, bad);
    $fatal(1, "timeout");
  end
endmodule
